tap_tms_sequencer: RTL and testbench

//  Initiator (master) side of the TAP link. Drives TMS/TDI/TRST toward a TAP controller and samples its TDO.

---
 rtl/tap_pkg.sv | 71 +++++++
 rtl/tap_tms_sequencer_if.sv | 29 ++
 rtl/tap_state_mirror.sv | 27 ++
 rtl/tap_tms_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_tap_tms_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tap_pkg.sv
// Shared TAP definitions: 1149.1 state codes, host command opcodes, and the
// next-state / shortest-walk helpers used by the sequencer and its mirror.
package tap_pkg;

  localparam logic [3:0] TLR   = 4'hF;
  localparam logic [3:0] RTI   = 4'hC;
  localparam logic [3:0] SelDR = 4'h7;
  localparam logic [3:0] CapDR = 4'h6;
  localparam logic [3:0] ShDR  = 4'h2;
  localparam logic [3:0] Ex1DR = 4'h1;
  localparam logic [3:0] PauDR = 4'h3;
  localparam logic [3:0] Ex2DR = 4'h0;
  localparam logic [3:0] UpdDR = 4'h5;
  localparam logic [3:0] SelIR = 4'h4;
  localparam logic [3:0] CapIR = 4'hE;
  localparam logic [3:0] ShIR  = 4'hA;
  localparam logic [3:0] Ex1IR = 4'h9;
  localparam logic [3:0] PauIR = 4'hB;
  localparam logic [3:0] Ex2IR = 4'h8;
  localparam logic [3:0] UpdIR = 4'hD;

  typedef enum logic [1:0] {
    OpGoto  = 2'b00,
    OpShift = 2'b01,
    OpReset = 2'b10,
    OpIdle  = 2'b11
  } cmd_op_e;

  function automatic logic [3:0] tap_next(input logic [3:0] state, input logic tms);
    case (state)
      TLR:     return tms ? TLR   : RTI;
      RTI:     return tms ? SelDR : RTI;
      SelDR:   return tms ? SelIR : CapDR;
      CapDR:   return tms ? Ex1DR : ShDR;
      ShDR:    return tms ? Ex1DR : ShDR;
      Ex1DR:   return tms ? UpdDR : PauDR;
      PauDR:   return tms ? Ex2DR : PauDR;
      Ex2DR:   return tms ? UpdDR : ShDR;
      UpdDR:   return tms ? SelDR : RTI;
      SelIR:   return tms ? TLR   : CapIR;
      CapIR:   return tms ? Ex1IR : ShIR;
      ShIR:    return tms ? Ex1IR : ShIR;
      Ex1IR:   return tms ? UpdIR : PauIR;
      PauIR:   return tms ? Ex2IR : PauIR;
      Ex2IR:   return tms ? UpdIR : ShIR;
      UpdIR:   return tms ? SelDR : RTI;
      default: return TLR;
    endcase
  endfunction

  // States the TAP can be parked in indefinitely with a constant TMS.
  function automatic logic is_stable(input logic [3:0] state);
    return (state == TLR) || (state == RTI) || (state == ShDR) || (state == PauDR) ||
           (state == ShIR) || (state == PauIR);
  endfunction

  // First TMS bit of the shortest walk cur -> tgt; each mask is indexed by the cur encoding.
  function automatic logic shortest_tms(input logic [3:0] cur, input logic [3:0] tgt);
    logic [15:0] mask;
    case (tgt)
      RTI:     mask = 16'h4FDF;
      ShDR:    mask = 16'h7F38;
      PauDR:   mask = 16'h7F74;
      ShIR:    mask = 16'h38EF;
      PauIR:   mask = 16'h74EF;
      default: mask = 16'hFFFF;
    endcase
    return mask[cur];
  endfunction

endpackage

// File: rtl/tap_tms_sequencer_if.sv
// Host command/response channel of the TAP sequencer: valid/ready command in,
// single-cycle response pulse out.
interface tap_tms_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6
);
  import tap_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  cmd_op_e           cmd_op;
  logic [3:0]        cmd_state;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_state, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_state, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/tap_state_mirror.sv
// Local copy of the remote TAP controller state, advanced with the TMS/TRST
// values the TAP samples on each rising edge.
module tap_state_mirror
  import tap_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tms_i,
  input  logic       trst_i,
  output logic [3:0] state_o,
  output logic [3:0] state_next_o
);

  logic [3:0] state_q;

  assign state_next_o = trst_i ? TLR : tap_next(state_q, tms_i);
  assign state_o      = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TLR;
    end else begin
      state_q <= state_next_o;
    end
  end

endmodule

// File: rtl/tap_tms_sequencer.sv
// TAP link initiator: turns host GOTO/SHIFT/RESET/IDLE commands into TMS/TDI/TRST
// pad activity, tracks the remote TAP state and returns captured TDO data.
module tap_tms_sequencer
  import tap_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LEN_W       = 6,
  parameter int unsigned SYNC_CYCLES = 5
) (
  input  logic                 GCLK_Pad,
  input  logic                 RSTN_Pad,
  tap_tms_sequencer_if.slave   cmd,
  input  logic                 TDO_Pad,
  output logic                 TMS_Pad,
  output logic                 TDI_Pad,
  output logic                 TRST_Pad,
  output logic [3:0]           tap_state
);

  typedef enum logic [2:0] {
    StSync, StReady, StWalk, StShift, StExit, StIdleRun, StRstPulse, StDone
  } st_e;

  st_e               st_q;
  logic              tms_q, tdi_q, trst_q;
  logic              ready_q, rsp_valid_q, rsp_err_q, rst_cmd_q;
  logic [DATA_W-1:0] rsp_data_q, cap_q, sh_q, bit_q;
  logic [LEN_W-1:0]  rem_q;
  logic [3:0]        tgt_q;
  logic [3:0]        mir_q, mir_d;
  logic              shift_ok;

  tap_state_mirror u_mirror (
    .clk_i        (GCLK_Pad),
    .rst_ni       (RSTN_Pad),
    .tms_i        (tms_q),
    .trst_i       (trst_q),
    .state_o      (mir_q),
    .state_next_o (mir_d)
  );

  assign shift_ok = ((mir_d == ShDR) || (mir_d == ShIR)) && (cmd.cmd_len != '0) &&
                    (cmd.cmd_len <= LEN_W'(DATA_W));

  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
    if (!RSTN_Pad) begin
      st_q        <= StSync;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rst_cmd_q   <= 1'b0;
      rsp_data_q  <= '0;
      cap_q       <= '0;
      sh_q        <= '0;
      bit_q       <= '0;
      rem_q       <= LEN_W'(SYNC_CYCLES);
      tgt_q       <= TLR;
    end else begin
      // Parking TMS keeps the TAP where the mirror says it will be next.
      tms_q  <= (mir_d == TLR);
      tdi_q  <= 1'b0;
      trst_q <= 1'b0;
      unique case (st_q)
        StSync: begin
          tms_q <= 1'b1;
          if (rem_q == LEN_W'(1)) begin
            rst_cmd_q <= 1'b0;
            if (rst_cmd_q) begin
              st_q        <= StDone;
              rsp_valid_q <= 1'b1;
            end else begin
              st_q    <= StReady;
              ready_q <= 1'b1;
            end
          end else begin
            rem_q <= rem_q - 1'b1;
          end
        end
        StReady: begin
          if (cmd.cmd_valid) begin
            ready_q <= 1'b0;
            unique case (cmd.cmd_op)
              OpGoto: begin
                if (!is_stable(cmd.cmd_state)) begin
                  st_q        <= StDone;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                end else if (cmd.cmd_state == mir_d) begin
                  st_q        <= StDone;
                  rsp_valid_q <= 1'b1;
                end else begin
                  tgt_q <= cmd.cmd_state;
                  tms_q <= shortest_tms(mir_d, cmd.cmd_state);
                  st_q  <= StWalk;
                end
              end
              OpShift: begin
                if (!shift_ok) begin
                  st_q        <= StDone;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                end else begin
                  tdi_q <= cmd.cmd_data[0];
                  sh_q  <= cmd.cmd_data >> 1;
                  tms_q <= (cmd.cmd_len == LEN_W'(1));
                  rem_q <= cmd.cmd_len;
                  bit_q <= DATA_W'(1);
                  cap_q <= '0;
                  st_q  <= StShift;
                end
              end
              OpReset: begin
                trst_q <= 1'b1;
                tms_q  <= 1'b1;
                st_q   <= StRstPulse;
              end
              OpIdle: begin
                if (mir_d != RTI) begin
                  st_q        <= StDone;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                end else if (cmd.cmd_len == '0) begin
                  st_q        <= StDone;
                  rsp_valid_q <= 1'b1;
                end else begin
                  rem_q <= cmd.cmd_len;
                  st_q  <= StIdleRun;
                end
              end
              default: st_q <= StDone;
            endcase
          end
        end
        StWalk: begin
          if (mir_d == tgt_q) begin
            st_q        <= StDone;
            rsp_valid_q <= 1'b1;
          end else begin
            tms_q <= shortest_tms(mir_d, tgt_q);
          end
        end
        StShift: begin
          // bit_q is a one-hot pointer to the rsp_data bit captured on this edge.
          cap_q <= cap_q | ({DATA_W{TDO_Pad}} & bit_q);
          bit_q <= bit_q << 1;
          if (rem_q == LEN_W'(1)) begin
            tms_q <= 1'b0;
            st_q  <= StExit;
          end else begin
            rem_q <= rem_q - 1'b1;
            tdi_q <= sh_q[0];
            sh_q  <= sh_q >> 1;
            tms_q <= (rem_q == LEN_W'(2));
          end
        end
        StExit: begin
          rsp_data_q  <= cap_q;
          rsp_valid_q <= 1'b1;
          st_q        <= StDone;
        end
        StIdleRun: begin
          if (rem_q == LEN_W'(1)) begin
            st_q        <= StDone;
            rsp_valid_q <= 1'b1;
          end else begin
            rem_q <= rem_q - 1'b1;
          end
        end
        StRstPulse: begin
          tms_q     <= 1'b1;
          rem_q     <= LEN_W'(SYNC_CYCLES);
          rst_cmd_q <= 1'b1;
          st_q      <= StSync;
        end
        StDone: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          ready_q     <= 1'b1;
          st_q        <= StReady;
        end
        default: st_q <= StSync;
      endcase
    end
  end

  assign TMS_Pad       = tms_q;
  assign TDI_Pad       = tdi_q;
  assign TRST_Pad      = trst_q;
  assign tap_state     = mir_q;
  assign cmd.cmd_ready = ready_q;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_err   = rsp_err_q;
  assign cmd.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_tap_tms_sequencer.sv
// Directed bench for tap_tms_sequencer: an independent TAP model with TDI looped
// to TDO, pad traces recorded per TAP edge and compared to hand-derived vectors.
module tb_tap_tms_sequencer;
  import tap_pkg::*;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned LEN_W       = 6;
  localparam int unsigned SYNC_CYCLES = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tdo, tms, tdi, trst;
  logic [3:0] tap_state;
  logic [3:0] state_obs = 4'hC;

  int n_checks = 0;
  int n_fail   = 0;

  tap_tms_sequencer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  tap_tms_sequencer #(
    .DATA_W      (DATA_W),
    .LEN_W       (LEN_W),
    .SYNC_CYCLES (SYNC_CYCLES)
  ) dut (
    .GCLK_Pad  (clk),
    .RSTN_Pad  (rst_n),
    .cmd       (bus),
    .TDO_Pad   (tdo),
    .TMS_Pad   (tms),
    .TDI_Pad   (tdi),
    .TRST_Pad  (trst),
    .tap_state (tap_state)
  );

  always #5 clk = ~clk;
  assign tdo = tdi;

  function automatic logic [3:0] ref_next(input logic [3:0] s, input logic m);
    case (s)
      4'hF: ref_next = m ? 4'hF : 4'hC;
      4'hC: ref_next = m ? 4'h7 : 4'hC;
      4'h7: ref_next = m ? 4'h4 : 4'h6;
      4'h6: ref_next = m ? 4'h1 : 4'h2;
      4'h2: ref_next = m ? 4'h1 : 4'h2;
      4'h1: ref_next = m ? 4'h5 : 4'h3;
      4'h3: ref_next = m ? 4'h0 : 4'h3;
      4'h0: ref_next = m ? 4'h5 : 4'h2;
      4'h5: ref_next = m ? 4'h7 : 4'hC;
      4'h4: ref_next = m ? 4'hF : 4'hE;
      4'hE: ref_next = m ? 4'h9 : 4'hA;
      4'hA: ref_next = m ? 4'h9 : 4'hA;
      4'h9: ref_next = m ? 4'hD : 4'hB;
      4'hB: ref_next = m ? 4'h8 : 4'hB;
      4'h8: ref_next = m ? 4'hD : 4'hA;
      default: ref_next = m ? 4'h7 : 4'hC;
    endcase
  endfunction

  always @(posedge clk or posedge trst) begin
    if (trst) state_obs <= 4'hF;
    else      state_obs <= ref_next(state_obs, tms);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one command and records TMS/TDI/TRST as sampled on each TAP edge until rsp_valid.
  task automatic run_cmd(input cmd_op_e op, input logic [3:0] tgt, input logic [LEN_W-1:0] len,
                         input logic [DATA_W-1:0] data, input string tag, output int n,
                         output logic [63:0] tms_v, output logic [63:0] tdi_v,
                         output logic [63:0] trst_v, output logic err);
    int   guard;
    logic acc;
    n = 0; tms_v = '0; tdi_v = '0; trst_v = '0; err = 1'b0;
    bus.cmd_op = op; bus.cmd_state = tgt; bus.cmd_len = len; bus.cmd_data = data;
    bus.cmd_valid = 1'b1;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 20) begin
      @(posedge clk);
      acc = bus.cmd_ready;
      guard++;
    end
    #1 bus.cmd_valid = 1'b0;
    if (!acc) begin
      check_eq({tag, " accept"}, 64'd0, 64'd1);
      return;
    end
    guard = 0;
    while (!bus.rsp_valid && guard < 60) begin
      @(posedge clk);
      tms_v[n] = tms; tdi_v[n] = tdi; trst_v[n] = trst;
      n++; guard++;
      #1;
      check_eq({tag, " mirror"}, 64'(tap_state), 64'(state_obs));
      check_eq({tag, " busy"}, 64'(bus.cmd_ready), 64'd0);
    end
    if (!bus.rsp_valid) begin
      check_eq({tag, " rsp timeout"}, 64'd0, 64'd1);
      return;
    end
    err = bus.rsp_err;
    @(posedge clk);
    #1;
    check_eq({tag, " rsp pulse"}, 64'(bus.rsp_valid), 64'd0);
    check_eq({tag, " ready"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [63:0] tv, dv, rv;
    logic        err, acc, tms_before;

    bus.cmd_valid = 1'b0; bus.cmd_op = OpGoto; bus.cmd_state = 4'h0;
    bus.cmd_len = '0; bus.cmd_data = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst tms", 64'(tms), 64'd1);
    check_eq("rst tdi", 64'(tdi), 64'd0);
    check_eq("rst trst", 64'(trst), 64'd0);
    check_eq("rst ready", 64'(bus.cmd_ready), 64'd0);
    check_eq("rst rsp", 64'({bus.rsp_valid, bus.rsp_err}), 64'd0);
    check_eq("rst data", 64'(bus.rsp_data), 64'd0);
    check_eq("rst state", 64'(tap_state), 64'hF);

    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      check_eq("sync tms", 64'(tms), 64'd1);
      #1;
      check_eq("sync ready", 64'(bus.cmd_ready), 64'(i == 5));
    end
    check_eq("sync obs", 64'(state_obs), 64'hF);
    check_eq("sync state", 64'(tap_state), 64'hF);

    run_cmd(OpGoto, ShDR, '0, '0, "goto shdr", n, tv, dv, rv, err);
    check_eq("goto shdr n", 64'(n), 64'd4);
    check_eq("goto shdr tms", tv, 64'h2);
    check_eq("goto shdr err", 64'(err), 64'd0);
    check_eq("goto shdr state", 64'(tap_state), 64'h2);

    run_cmd(OpGoto, ShDR, '0, '0, "goto same", n, tv, dv, rv, err);
    check_eq("goto same n", 64'(n), 64'd0);
    check_eq("goto same err", 64'(err), 64'd0);

    run_cmd(OpShift, 4'h0, 6'd8, 32'hA5, "shift8", n, tv, dv, rv, err);
    check_eq("shift8 n", 64'(n), 64'd9);
    check_eq("shift8 tms", tv, 64'h80);
    check_eq("shift8 tdi", dv, 64'hA5);
    check_eq("shift8 data", 64'(bus.rsp_data), 64'hA5);
    check_eq("shift8 state", 64'(tap_state), 64'h3);

    run_cmd(OpGoto, ShIR, '0, '0, "goto shir", n, tv, dv, rv, err);
    check_eq("goto shir n", 64'(n), 64'd6);
    check_eq("goto shir tms", tv, 64'h0F);
    check_eq("goto shir state", 64'(tap_state), 64'hA);

    run_cmd(OpShift, 4'h0, 6'd32, 32'hDEADBEEF, "shift32", n, tv, dv, rv, err);
    check_eq("shift32 n", 64'(n), 64'd33);
    check_eq("shift32 tms", tv, 64'h8000_0000);
    check_eq("shift32 tdi", dv, 64'hDEAD_BEEF);
    check_eq("shift32 data", 64'(bus.rsp_data), 64'hDEAD_BEEF);
    check_eq("shift32 state", 64'(tap_state), 64'hB);

    run_cmd(OpGoto, RTI, '0, '0, "goto rti", n, tv, dv, rv, err);
    check_eq("goto rti n", 64'(n), 64'd3);
    check_eq("goto rti tms", tv, 64'h3);
    check_eq("goto rti state", 64'(tap_state), 64'hC);

    tms_before = tms;
    run_cmd(OpShift, 4'h0, 6'd4, 32'hF, "err shift rti", n, tv, dv, rv, err);
    check_eq("err shift rti err", 64'(err), 64'd1);
    check_eq("err shift rti n", 64'(n), 64'd0);
    check_eq("err shift rti tms", 64'(tms), 64'(tms_before));
    check_eq("err shift rti tdi", 64'(tdi), 64'd0);
    check_eq("err shift rti state", 64'(tap_state), 64'hC);
    check_eq("err shift rti held", 64'(bus.rsp_data), 64'hDEAD_BEEF);

    run_cmd(OpGoto, CapDR, '0, '0, "err goto capdr", n, tv, dv, rv, err);
    check_eq("err goto capdr err", 64'(err), 64'd1);
    check_eq("err goto capdr n", 64'(n), 64'd0);
    check_eq("err goto capdr state", 64'(tap_state), 64'hC);

    run_cmd(OpIdle, 4'h0, 6'd3, '0, "idle3", n, tv, dv, rv, err);
    check_eq("idle3 n", 64'(n), 64'd3);
    check_eq("idle3 tms", tv, 64'h0);
    check_eq("idle3 err", 64'(err), 64'd0);

    run_cmd(OpIdle, 4'h0, 6'd0, '0, "idle0", n, tv, dv, rv, err);
    check_eq("idle0 n", 64'(n), 64'd0);
    check_eq("idle0 err", 64'(err), 64'd0);

    run_cmd(OpGoto, ShDR, '0, '0, "goto shdr2", n, tv, dv, rv, err);
    check_eq("goto shdr2 n", 64'(n), 64'd3);
    check_eq("goto shdr2 tms", tv, 64'h1);

    run_cmd(OpShift, 4'h0, 6'd0, 32'h1, "err len0", n, tv, dv, rv, err);
    check_eq("err len0 err", 64'(err), 64'd1);
    check_eq("err len0 n", 64'(n), 64'd0);
    run_cmd(OpShift, 4'h0, 6'd33, 32'h1, "err len33", n, tv, dv, rv, err);
    check_eq("err len33 err", 64'(err), 64'd1);
    check_eq("err len33 state", 64'(tap_state), 64'h2);

    run_cmd(OpReset, 4'h0, '0, '0, "reset op", n, tv, dv, rv, err);
    check_eq("reset op n", 64'(n), 64'd6);
    check_eq("reset op tms", tv, 64'h3F);
    check_eq("reset op trst", rv, 64'h1);
    check_eq("reset op err", 64'(err), 64'd0);
    check_eq("reset op state", 64'(tap_state), 64'hF);
    check_eq("reset op obs", 64'(state_obs), 64'hF);

    // Abort a SHIFT after three bits with the async reset.
    run_cmd(OpGoto, ShDR, '0, '0, "goto shdr3", n, tv, dv, rv, err);
    check_eq("goto shdr3 n", 64'(n), 64'd4);
    bus.cmd_op = OpShift; bus.cmd_len = 6'd8; bus.cmd_data = 32'hA5; bus.cmd_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(posedge clk);
      acc = bus.cmd_ready;
    end
    #1 bus.cmd_valid = 1'b0;
    check_eq("abort accept", 64'(acc), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort tms", 64'(tms), 64'd1);
    check_eq("abort tdi", 64'(tdi), 64'd0);
    check_eq("abort state", 64'(tap_state), 64'hF);
    check_eq("abort data", 64'(bus.rsp_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort rsp", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      check_eq("resync tms", 64'(tms), 64'd1);
      #1;
      check_eq("resync ready", 64'(bus.cmd_ready), 64'(i == 5));
      check_eq("resync rsp", 64'(bus.rsp_valid), 64'd0);
    end
    check_eq("resync obs", 64'(state_obs), 64'hF);

    run_cmd(OpGoto, RTI, '0, '0, "goto rti2", n, tv, dv, rv, err);
    check_eq("goto rti2 n", 64'(n), 64'd1);
    check_eq("goto rti2 tms", tv, 64'h0);
    check_eq("goto rti2 state", 64'(tap_state), 64'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
